mem_1r1w_bist: RTL and testbench

MEM_1R1W_BIST -- requirements
Module: mem_1r1w_bist

---
 rtl/mem_1r1w_bist.sv | 122 ++++++++++++
 tb/tb_mem_1r1w_bist.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_1r1w_bist.sv
// Built-in self test for a 1r1w memory: writes P0, reads/checks it, writes P1,
// reads/checks it, and reports pass or the first failing address.
module mem_1r1w_bist #(
    parameter int DEPTH  = 48,
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [ADDR_W-1:0] R0_addr,
    output logic              R0_en,
    input  logic [WIDTH-1:0]  R0_data,
    output logic [ADDR_W-1:0] W0_addr,
    output logic              W0_en,
    output logic [WIDTH-1:0]  W0_data
);

    if ((2 ** ADDR_W) < DEPTH) begin : g_bad_addr_w
        $error("ADDR_W too small for DEPTH");
    end

    typedef enum logic [2:0] {IDLE, WR0, RD0, DRN0, WR1, RD1, DRN1, FIN} state_t;

    localparam int REP = (WIDTH + 63) / 64;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state, next_state;
    logic [ADDR_W-1:0] cnt, next_cnt, cnt_inc;
    logic [ADDR_W-1:0] chk_addr;
    logic              chk_valid, chk_ph, mismatch, start_ok;

    // 64-bit base pattern replicated then truncated to WIDTH; ph=1 selects P1
    function automatic logic [WIDTH-1:0] pattern(input logic [ADDR_W-1:0] a, input logic ph);
        logic [63:0]       base;
        logic [64*REP-1:0] rep;
        base = 64'h5555_5555_5555_5555 ^ 64'(a);
        rep  = {REP{base}};
        return ph ? ~rep[WIDTH-1:0] : rep[WIDTH-1:0];
    endfunction

    assign cnt_inc  = (cnt == LAST) ? '0 : cnt + ADDR_W'(1);
    assign mismatch = chk_valid && (R0_data != pattern(chk_addr, chk_ph));
    assign start_ok = start && (state == IDLE || state == FIN);

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            IDLE, FIN: begin
                if (start) begin
                    next_state = WR0;
                    next_cnt   = '0;
                end
            end
            WR0: begin
                next_cnt = cnt_inc;
                if (cnt == LAST) next_state = RD0;
            end
            RD0: begin
                next_cnt = cnt_inc;
                if (cnt == LAST) next_state = DRN0;
            end
            DRN0: next_state = WR1;
            WR1: begin
                next_cnt = cnt_inc;
                if (cnt == LAST) next_state = RD1;
            end
            RD1: begin
                next_cnt = cnt_inc;
                if (cnt == LAST) next_state = DRN1;
            end
            DRN1:    next_state = FIN;
            default: next_state = IDLE;
        endcase
        if (mismatch) next_state = FIN;
    end

    // Memory-side outputs are registered from the next state so they line up
    // with the state they belong to and hold while their enable is low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            R0_en     <= 1'b0;
            W0_en     <= 1'b0;
            R0_addr   <= '0;
            W0_addr   <= '0;
            W0_data   <= '0;
            chk_valid <= 1'b0;
            chk_addr  <= '0;
            chk_ph    <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            busy  <= !(next_state == IDLE || next_state == FIN);
            done  <= (next_state == FIN);
            R0_en <= (next_state == RD0 || next_state == RD1);
            W0_en <= (next_state == WR0 || next_state == WR1);
            if (next_state == RD0 || next_state == RD1) R0_addr <= next_cnt;
            if (next_state == WR0 || next_state == WR1) begin
                W0_addr <= next_cnt;
                W0_data <= pattern(next_cnt, next_state == WR1);
            end
            chk_valid <= R0_en && !mismatch;
            chk_addr  <= R0_addr;
            chk_ph    <= (state == RD1);
            if (mismatch) fail_addr <= chk_addr;
            if (start_ok) pass <= 1'b0;
            else if (state == DRN1 && !mismatch) pass <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_1r1w_bist.sv
// Directed bench for mem_1r1w_bist with a behavioural 1r1w memory that can
// inject a bit flip or an address alias, and a scoreboard of run results.
module tb_mem_1r1w_bist;

    localparam int DEPTH  = 48;
    localparam int WIDTH  = 64;
    localparam int ADDR_W = 6;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              busy, done, pass;
    logic [ADDR_W-1:0] fail_addr, R0_addr, W0_addr;
    logic              R0_en, W0_en;
    logic [WIDTH-1:0]  R0_data, W0_data;

    mem_1r1w_bist #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .pass(pass), .fail_addr(fail_addr), .R0_addr(R0_addr), .R0_en(R0_en),
        .R0_data(R0_data), .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int fault_mode = 0;

    logic [WIDTH-1:0] mem [0:(2**ADDR_W)-1];

    // mode 1: bit 3 of address 40 reads flipped; mode 2: address 33 reads address 1
    always @(posedge clock) begin : memory_model
        logic [ADDR_W-1:0] ra;
        logic [WIDTH-1:0]  d;
        if (W0_en) mem[W0_addr] <= W0_data;
        if (R0_en) begin
            ra = (fault_mode == 2 && R0_addr == 6'd33) ? 6'd1 : R0_addr;
            d  = mem[ra];
            if (fault_mode == 1 && R0_addr == 6'd40) d[3] = ~d[3];
            R0_data <= d;
        end
    end

    function automatic logic [63:0] tb_pat(input int a, input bit ph);
        logic [63:0] p;
        p = 64'h5555_5555_5555_5555 ^ 64'(a);
        return ph ? ~p : p;
    endfunction

    int busy_tot = 0, wr_tot = 0, rd_tot = 0, both_tot = 0;
    int en_done_tot = 0, wseq_err = 0, addr_err = 0;
    int exp_waddr = 0;
    bit exp_ph = 1'b0;

    always @(negedge clock) begin : monitor
        if (!reset_n) begin
            exp_waddr = 0;
            exp_ph    = 1'b0;
        end else begin
            if (start && !busy) begin
                exp_waddr = 0;
                exp_ph    = 1'b0;
            end
            if (busy) busy_tot++;
            if (W0_en) begin
                wr_tot++;
                if (W0_addr !== ADDR_W'(exp_waddr) || W0_data !== tb_pat(exp_waddr, exp_ph)) wseq_err++;
                if (exp_waddr == DEPTH - 1) begin
                    exp_waddr = 0;
                    exp_ph    = ~exp_ph;
                end else begin
                    exp_waddr++;
                end
            end
            if (R0_en) rd_tot++;
            if (R0_en && int'(R0_addr) >= DEPTH) addr_err++;
            if (W0_en && int'(W0_addr) >= DEPTH) addr_err++;
            if (R0_en && W0_en) both_tot++;
            if (done && (R0_en || W0_en)) en_done_tot++;
        end
    end

    typedef struct {
        logic              pass;
        logic [ADDR_W-1:0] fa;
        int                cyc;
        int                wr;
        int                rd;
        bit                full;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic run(input string nm, input int fmode, input logic ep,
                       input logic [ADDR_W-1:0] efa, input bit full, input bit hold);
        exp_t e;
        bit   ok;
        int   b_busy, b_wr, b_rd, b_both, b_endone, b_seq, b_addr;
        @(posedge clock); #1;
        fault_mode = fmode;
        b_busy = busy_tot; b_wr = wr_tot; b_rd = rd_tot; b_both = both_tot;
        b_endone = en_done_tot; b_seq = wseq_err; b_addr = addr_err;
        sb.push_back('{pass: ep, fa: efa, cyc: 4*DEPTH+2, wr: 2*DEPTH, rd: 2*DEPTH, full: full});
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        check({nm, "_busy_up"}, 64'(busy), 64'(1));
        check({nm, "_done_clr"}, 64'(done), 64'(0));
        check({nm, "_pass_clr"}, 64'(pass), 64'(0));
        if (hold) begin
            @(posedge clock); #1;
            repeat (4) @(posedge clock);
            #1 start = 1'b1;
            repeat (10) @(posedge clock);
            #1 start = 1'b0;
        end
        wait_done(ok);
        check({nm, "_done_seen"}, 64'(ok), 64'(1));
        e = sb.pop_front();
        check({nm, "_pass"}, 64'(pass), 64'(e.pass));
        if (!e.pass) check({nm, "_fail_addr"}, 64'(fail_addr), 64'(e.fa));
        check({nm, "_busy_fin"}, 64'(busy), 64'(0));
        if (e.full) begin
            check({nm, "_busy_cycles"}, 64'(busy_tot - b_busy), 64'(e.cyc));
            check({nm, "_writes"}, 64'(wr_tot - b_wr), 64'(e.wr));
            check({nm, "_reads"}, 64'(rd_tot - b_rd), 64'(e.rd));
        end
        check({nm, "_rw_overlap"}, 64'(both_tot - b_both), 64'(0));
        check({nm, "_write_seq"}, 64'(wseq_err - b_seq), 64'(0));
        check({nm, "_addr_range"}, 64'(addr_err - b_addr), 64'(0));
        repeat (4) @(negedge clock);
        #1;
        check({nm, "_done_hold"}, 64'(done), 64'(1));
        check({nm, "_en_in_fin"}, 64'(en_done_tot - b_endone), 64'(0));
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, "_busy"}, 64'(busy), 64'(0));
        check({nm, "_done"}, 64'(done), 64'(0));
        check({nm, "_pass"}, 64'(pass), 64'(0));
        check({nm, "_fail_addr"}, 64'(fail_addr), 64'(0));
        check({nm, "_R0_en"}, 64'(R0_en), 64'(0));
        check({nm, "_W0_en"}, 64'(W0_en), 64'(0));
        check({nm, "_R0_addr"}, 64'(R0_addr), 64'(0));
        check({nm, "_W0_addr"}, 64'(W0_addr), 64'(0));
        check({nm, "_W0_data"}, 64'(W0_data), 64'(0));
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check_reset_vals("rst");
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_busy", 64'(busy), 64'(0));

        run("pass1", 0, 1'b1, '0, 1'b1, 1'b0);
        run("hold_start", 0, 1'b1, '0, 1'b1, 1'b1);
        run("flip40", 1, 1'b0, 6'd40, 1'b0, 1'b0);
        run("rerun_fin", 0, 1'b1, '0, 1'b1, 1'b0);
        run("alias33", 2, 1'b0, 6'd33, 1'b0, 1'b0);
        run("pass2", 0, 1'b1, '0, 1'b1, 1'b0);

        // Reset asserted between clock edges while reading back P0
        @(posedge clock); #1;
        fault_mode = 0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (79) @(posedge clock);
        #2;
        check("midrst_pre_R0_en", 64'(R0_en), 64'(1));
        reset_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (5) @(negedge clock);
        check("midrst_idle_busy", 64'(busy), 64'(0));
        check("midrst_idle_done", 64'(done), 64'(0));
        run("after_rst", 0, 1'b1, '0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
